// File: rtl/d_flip_flop_4bit.sv
// WIDTH-bit D register with true and complemented outputs.
// Async clear/preset take effect immediately; sync reset/set/data load on the rising clk edge.
module d_flip_flop_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             preset,
    input  logic             set,
    input  logic             reset,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] nq
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_d;

    // Synchronous next value: reset beats set, and both beat data.
    always_comb begin
        w_d = data;
        if (reset) begin
            w_d = '0;
        end else if (set) begin
            w_d = '1;
        end
    end

    // clear beats preset. Either one held high also wins any clk edge it overlaps.
    always_ff @(posedge clk or posedge clear or posedge preset) begin
        if (clear) begin
            r_q <= '0;
        end else if (preset) begin
            r_q <= '1;
        end else begin
            r_q <= w_d;
        end
    end

    assign q  = r_q;
    assign nq = ~r_q;

endmodule

// File: tb/tb_d_flip_flop_4bit.sv
// Self-checking bench for d_flip_flop_4bit: directed timeline, then randomized
// cycles checked against a priority-rule reference model.
module tb_d_flip_flop_4bit;

    logic       clk = 1'b0;
    logic       clear = 1'b0;
    logic       preset = 1'b0;
    logic       set = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] data = 4'b1010;
    logic [3:0] q;
    logic [3:0] nq;

    int n_checks = 0;
    int n_errors = 0;

    d_flip_flop_4bit #(.WIDTH(4)) dut (
        .clk    (clk),
        .clear  (clear),
        .preset (preset),
        .set    (set),
        .reset  (reset),
        .data   (data),
        .q      (q),
        .nq     (nq)
    );

    always #25 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at t=%0t: got %h, expected %h", tag, $time, obs, exp);
        end
    endtask

    task automatic chk_q(input string tag, input logic [3:0] exp);
        chk({tag, ".q"}, q, exp);
        chk({tag, ".nq"}, nq, ~exp);
    endtask

    task automatic at(input time t);
        if (t > $time) #(t - $time);
    endtask

    // Value the register must take on a rising edge when no async input is high.
    function automatic logic [3:0] model_edge(input logic rs, input logic st, input logic [3:0] d);
        if (rs) return 4'h0;
        if (st) return 4'hF;
        return d;
    endfunction

    logic [3:0] exp_q;

    initial begin
        // Directed timeline
        preset = 1'b1;
        #1  chk_q("preset_imm", 4'hF);
        at(30);  chk_q("preset_edge25", 4'hF);
        at(40);  preset = 1'b0; clear = 1'b1;
        #1  chk_q("clear_imm", 4'h0);
        at(76);  chk_q("clear_edge75", 4'h0);
        at(80);  clear = 1'b0; set = 1'b1;
        at(120); chk_q("set_before_edge", 4'h0);
        at(126); chk_q("set_edge125", 4'hF);
        at(176); chk_q("set_hold175", 4'hF);
        at(190); set = 1'b0; reset = 1'b1;
        at(220); chk_q("reset_before_edge", 4'hF);
        at(226); chk_q("reset_edge225", 4'h0);
        at(276); chk_q("reset_hold275", 4'h0);
        at(300); reset = 1'b0;
        at(326); chk_q("data_edge325", 4'b1010);
        at(350); data = 4'b0110;
        at(360); chk_q("data_midcycle", 4'b1010);
        at(376); chk_q("data_edge375", 4'b0110);
        at(380); set = 1'b1; reset = 1'b1;
        at(426); chk_q("reset_over_set", 4'h0);
        at(430); set = 1'b0; reset = 1'b0;
        at(476); chk_q("reload_edge475", 4'b0110);
        at(480); preset = 1'b1; clear = 1'b1;
        #1  chk_q("clear_over_preset", 4'h0);
        at(490); preset = 1'b0; clear = 1'b0;
        at(526); chk_q("reload_edge525", 4'b0110);
        at(530); set = 1'b1;
        at(540); clear = 1'b1;
        #1  chk_q("clear_midcycle_imm", 4'h0);
        at(576); chk_q("clear_held575", 4'h0);
        at(626); chk_q("clear_held625", 4'h0);
        at(630); clear = 1'b0;
        at(676); chk_q("set_after_clear", 4'hF);
        exp_q = 4'hF;

        // Randomized cycles against the reference model
        for (int i = 0; i < 300; i++) begin
            int sel;
            @(negedge clk);
            reset = ($urandom_range(0, 4) == 0);
            set   = ($urandom_range(0, 4) == 0);
            data  = 4'($urandom);
            sel   = $urandom_range(0, 9);
            if (sel < 2) begin
                #5;
                clear  = (sel == 0) || ($urandom_range(0, 3) == 0);
                preset = (sel == 1) || ($urandom_range(0, 3) == 0);
                exp_q  = clear ? 4'h0 : 4'hF;
                #1 chk_q("rnd_async_imm", exp_q);
                #5;
                clear  = 1'b0;
                preset = 1'b0;
                #1 chk_q("rnd_async_release", exp_q);
            end else begin
                #1 chk_q("rnd_hold", exp_q);
            end
            @(posedge clk);
            exp_q = model_edge(reset, set, data);
            #1 chk_q("rnd_edge", exp_q);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout at t=%0t: got running, expected finished", $time);
        $fatal(1);
    end

endmodule
